source_sel_ctrl: RTL and testbench

//  Front-panel controller for the 4:1 test-source mux (counter/PRBS/const/const_bar) feeding FMCA.

---
 rtl/source_sel_if.sv | 31 +++
 rtl/source_sel_ctrl.sv | 179 +++++++++++++++++
 tb/tb_source_sel_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/source_sel_if.sv
// source_sel_if: front-panel buttons into the source-select controller,
// mux select and LED drives back out.
interface source_sel_if;
    logic       pb_next_n;
    logic       pb_mode_n;
    logic [1:0] sel;
    logic [1:0] indic;
    logic       led_auto;
    logic       blank;
    logic       sel_chg;

    modport master (
        output pb_next_n,
        output pb_mode_n,
        input  sel,
        input  indic,
        input  led_auto,
        input  blank,
        input  sel_chg
    );

    modport slave (
        input  pb_next_n,
        input  pb_mode_n,
        output sel,
        output indic,
        output led_auto,
        output blank,
        output sel_chg
    );
endinterface

// File: rtl/source_sel_ctrl.sv
// source_sel_ctrl: debounced front-panel stepping of the 4:1 test-source
// mux select, with timed auto-scan and a blanking window on every change.

module source_sel_db #(
    parameter int DB_CYCLES = 1600000,
    parameter int DB_W      = 21
) (
    input  logic clk160,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      sync_q, sync_d;
    logic            stable_q, stable_d;
    logic            dly_q, dly_d;
    logic            press_q, press_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Synchronise, filter short glitches, then flag the 1->0 edge.
    always_comb begin
        sync_d   = {sync_q[0], btn_n};
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == DB_LAST) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
        dly_d   = stable_q;
        press_d = dly_q & ~stable_q;
    end

    // Released is the idle level for every stage of the button path.
    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            dly_q    <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            dly_q    <= dly_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

module source_sel_ctrl #(
    parameter int DB_CYCLES = 1600000,
    parameter int DB_W      = 21,
    parameter int DWELL_CYC = 160000000,
    parameter int DWELL_W   = 28,
    parameter int BLANK_CYC = 64
) (
    input  logic         clk160,
    input  logic         rst_n,
    source_sel_if.slave  io
);
    localparam int BLK_W =
        (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST =
        BLK_W'(BLANK_CYC - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST =
        DWELL_W'(DWELL_CYC - 1);

    typedef enum logic {
        S_HOLD,
        S_BLANK
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic               auto_q, auto_d;
    logic               blank_q, blank_d;
    logic               chg_q, chg_d;
    logic [BLK_W-1:0]   bcnt_q, bcnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               next_press;
    logic               mode_press;
    logic               adv;

    source_sel_db #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db_next (
        .clk160 (clk160),
        .rst_n  (rst_n),
        .btn_n  (io.pb_next_n),
        .press  (next_press)
    );

    source_sel_db #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db_mode (
        .clk160 (clk160),
        .rst_n  (rst_n),
        .btn_n  (io.pb_mode_n),
        .press  (mode_press)
    );

    // Advance on a press or dwell expiry; hold off during the blank window.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        auto_d  = auto_q;
        blank_d = blank_q;
        chg_d   = 1'b0;
        bcnt_d  = bcnt_q;
        dwell_d = '0;
        adv     = 1'b0;
        if (mode_press) begin
            auto_d = ~auto_q;
        end
        unique case (state_q)
            S_HOLD: begin
                adv = next_press |
                      (auto_q & (dwell_q == DWELL_LAST));
                if (adv) begin
                    sel_d   = sel_q + 2'd1;
                    chg_d   = 1'b1;
                    blank_d = 1'b1;
                    bcnt_d  = '0;
                    state_d = S_BLANK;
                end else if (auto_q && !mode_press) begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            S_BLANK: begin
                if (bcnt_q == BLK_LAST) begin
                    blank_d = 1'b0;
                    bcnt_d  = '0;
                    state_d = S_HOLD;
                end else begin
                    bcnt_d = bcnt_q + BLK_W'(1);
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    // Controller state; reset drops any blank or change pulse at once.
    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HOLD;
            sel_q   <= 2'b00;
            auto_q  <= 1'b0;
            blank_q <= 1'b0;
            chg_q   <= 1'b0;
            bcnt_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            auto_q  <= auto_d;
            blank_q <= blank_d;
            chg_q   <= chg_d;
            bcnt_q  <= bcnt_d;
            dwell_q <= dwell_d;
        end
    end

    assign io.sel      = sel_q;
    assign io.indic    = sel_q;
    assign io.led_auto = auto_q;
    assign io.blank    = blank_q;
    assign io.sel_chg  = chg_q;
endmodule

// File: tb/tb_source_sel_ctrl.sv
// tb_source_sel_ctrl: randomized button stimulus against an event-time
// reference model, with a scoreboard of expected source changes.
module tb_source_sel_ctrl;
    localparam int DB    = 4;
    localparam int DWELL = 20;
    localparam int BLANK = 3;
    localparam int LAT   = 4;

    logic clk160 = 1'b0;
    logic rst_n  = 1'b0;

    source_sel_if bus();

    source_sel_ctrl #(
        .DB_CYCLES (DB),
        .DB_W      (3),
        .DWELL_CYC (DWELL),
        .DWELL_W   (5),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk160 (clk160),
        .rst_n  (rst_n),
        .io     (bus.slave)
    );

    always #5 clk160 = ~clk160;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         at;
        logic [1:0] sel;
    } exp_t;

    exp_t sb[$];

    int         cyc = 0;
    logic [1:0] m_sel;
    logic       m_auto;
    logic       exp_blank;
    logic       exp_chg;
    int         adv_at;
    int         z;
    logic [1:0] m_stable;
    int         run [2];
    int         ev_next[$];
    int         ev_mode[$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sel     = 2'b00;
        m_auto    = 1'b0;
        exp_blank = 1'b0;
        exp_chg   = 1'b0;
        adv_at    = -1000;
        z         = cyc;
        m_stable  = 2'b11;
        run[0]    = 0;
        run[1]    = 0;
        ev_next.delete();
        ev_mode.delete();
        sb.delete();
    endtask

    // Reference: a button press is DB consecutive low samples and takes
    // effect LAT edges later; source changes are tracked as edge times.
    task automatic model_step();
        logic [1:0] raw;
        logic nx, md, hold, adv, inc;
        cyc++;
        raw = {bus.pb_mode_n, bus.pb_next_n};
        for (int b = 0; b < 2; b++) begin
            if (raw[b] != m_stable[b]) begin
                run[b]++;
                if (run[b] == DB) begin
                    m_stable[b] = raw[b];
                    run[b] = 0;
                    if (!raw[b]) begin
                        if (b == 0) ev_next.push_back(cyc + LAT);
                        else        ev_mode.push_back(cyc + LAT);
                    end
                end
            end else begin
                run[b] = 0;
            end
        end
        nx = 1'b0;
        md = 1'b0;
        if (ev_next.size() > 0 && ev_next[0] == cyc) begin
            nx = 1'b1;
            void'(ev_next.pop_front());
        end
        if (ev_mode.size() > 0 && ev_mode[0] == cyc) begin
            md = 1'b1;
            void'(ev_mode.pop_front());
        end
        hold = (cyc > adv_at + BLANK);
        adv  = hold && (nx || (m_auto && (cyc - z == DWELL)));
        inc  = hold && m_auto && !adv && !md;
        if (adv) begin
            m_sel  = m_sel + 2'd1;
            adv_at = cyc;
            sb.push_back('{at: cyc, sel: m_sel});
        end
        if (md) m_auto = !m_auto;
        if (!inc) z = cyc;
        exp_blank = (cyc - adv_at) < BLANK;
        exp_chg   = (cyc == adv_at);
    endtask

    // Model advances on every active edge and resets with the DUT.
    initial begin
        model_reset();
        forever begin
            @(posedge clk160 or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Monitor: compare outputs each cycle, pop the scoreboard on sel_chg.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk160);
            if (rst_n) begin
                check("outputs",
                      {bus.sel, bus.indic, bus.led_auto,
                       bus.blank, bus.sel_chg},
                      {m_sel, m_sel, m_auto, exp_blank, exp_chg});
                if (bus.sel_chg) begin
                    check("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("sb_cycle", cyc, e.at);
                        check("sb_sel", bus.sel, e.sel);
                    end
                end
                while (sb.size() > 0 && sb[0].at < cyc) begin
                    check("sb_missed", cyc, sb[0].at);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk160);
    endtask

    task automatic press(input int b, input int lo, input int hi);
        if (b == 0) bus.pb_next_n = 1'b0;
        else        bus.pb_mode_n = 1'b0;
        idle(lo);
        bus.pb_next_n = 1'b1;
        bus.pb_mode_n = 1'b1;
        idle(hi);
    endtask

    task automatic press_both(input int lo, input int hi);
        bus.pb_next_n = 1'b0;
        bus.pb_mode_n = 1'b0;
        idle(lo);
        bus.pb_next_n = 1'b1;
        bus.pb_mode_n = 1'b1;
        idle(hi);
    endtask

    task automatic do_reset(input int n);
        #2 rst_n = 1'b0;
        idle(n);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic found;
        bus.pb_next_n = 1'b1;
        bus.pb_mode_n = 1'b1;
        #1;
        check("rst_sel", bus.sel, 0);
        check("rst_indic", bus.indic, 0);
        check("rst_led_auto", bus.led_auto, 0);
        check("rst_blank", bus.blank, 0);
        check("rst_sel_chg", bus.sel_chg, 0);
        idle(3);
        #2 rst_n = 1'b1;
        idle(2);

        press(0, 10, 20);

        repeat (8) begin
            press(0, $urandom_range(2, 3), $urandom_range(1, 3));
        end
        idle(10);

        repeat (4) press(0, 6, 10);

        press(1, 5, 70);
        press(1, 5, 40);

        press(1, 5, 5);
        for (int k = 0; k < 40; k++) begin
            press(0, $urandom_range(4, 6), $urandom_range(4, 12));
        end
        repeat (4) press_both(5, $urandom_range(6, 30));
        idle(30);

        for (int k = 0; k < 400; k++) begin
            @(negedge clk160);
            if ($urandom_range(0, 5) == 0)
                bus.pb_next_n = ~bus.pb_next_n;
            if ($urandom_range(0, 7) == 0)
                bus.pb_mode_n = ~bus.pb_mode_n;
        end
        bus.pb_next_n = 1'b1;
        bus.pb_mode_n = 1'b1;
        idle(40);

        if (!m_auto) press(1, 5, 5);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk160);
            if (bus.sel_chg && bus.sel == 2'd2) found = 1'b1;
        end
        check("t6_reach_sel2", found, 1);
        check("t6_blank_before", bus.blank, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_sel", bus.sel, 0);
        check("t6_indic", bus.indic, 0);
        check("t6_blank", bus.blank, 0);
        check("t6_led_auto", bus.led_auto, 0);
        check("t6_sel_chg", bus.sel_chg, 0);
        idle(3);
        #2 rst_n = 1'b1;
        idle(2);

        press(0, 6, 15);
        idle(10);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
